// File: rtl/sam_mem_pkg.sv
// Shared types and constants for the SAM memory bus arbiter.
package sam_mem_pkg;
  localparam int AW_DEF        = 8;
  localparam int DW_DEF        = 8;
  localparam int MEM_DEPTH_DEF = 64;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_CON  = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
endpackage

// File: rtl/sam_rr_pick2.sv
// Two-way combinational round-robin pick; on a tie the side that did not win last time gets it.
module sam_rr_pick2 (
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  output logic       o_grant_valid,
  output logic       o_grant_id
);
  assign o_grant_valid = |i_req;
  assign o_grant_id    = (&i_req) ? ~i_last_owner : i_req[1];
endmodule

// File: rtl/sam_mem_arbiter.sv
// Shares the single SAM memory bus between the CPU and the console/loader port,
// one memory cycle per grant, with a one-cycle ack back to the winner.
module sam_mem_arbiter
  import sam_mem_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_err,
  output logic [DW-1:0] cpu_rdata,
  input  logic          con_req,
  input  logic          con_rw,
  input  logic [AW-1:0] con_addr,
  input  logic [DW-1:0] con_wdata,
  output logic          con_ack,
  output logic          con_err,
  output logic [DW-1:0] con_rdata,
  input  logic          hold_cpu,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);
  localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

  state_t        r_state, w_state_nxt;
  logic          r_rw, r_err, r_owner;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata, r_cpu_rdata, r_con_rdata;

  logic          w_gnt_valid, w_gnt_id, w_gnt_rw, w_oor;
  logic [AW-1:0] w_gnt_addr;
  logic [DW-1:0] w_gnt_wdata;
  logic          w_ack;

  sam_rr_pick2 u_pick (
    .i_req        ({con_req, cpu_req & ~hold_cpu}),
    .i_last_owner (r_owner),
    .o_grant_valid(w_gnt_valid),
    .o_grant_id   (w_gnt_id)
  );

  assign w_gnt_rw    = (w_gnt_id == OWN_CON) ? con_rw    : cpu_rw;
  assign w_gnt_addr  = (w_gnt_id == OWN_CON) ? con_addr  : cpu_addr;
  assign w_gnt_wdata = (w_gnt_id == OWN_CON) ? con_wdata : cpu_wdata;
  assign w_oor       = 32'(w_gnt_addr) >= DEPTH_U;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt_valid) w_state_nxt = w_oor ? ACK : ISSUE;
      ISSUE:   w_state_nxt = (r_rw == RW_READ) ? WAIT : ACK;
      WAIT:    w_state_nxt = ACK;
      ACK:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Owner resets to the console so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rw        <= RW_WRITE;
      r_err       <= 1'b0;
      r_owner     <= OWN_CON;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_rdata <= '0;
      r_con_rdata <= '0;
    end else begin
      if (r_state == IDLE && w_gnt_valid) begin
        r_rw    <= w_gnt_rw;
        r_addr  <= w_gnt_addr;
        r_wdata <= w_gnt_wdata;
        r_err   <= w_oor;
        r_owner <= w_gnt_id;
      end
      if (r_state == WAIT) begin
        if (r_owner == OWN_CPU) r_cpu_rdata <= mem_rdata;
        else                    r_con_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state == ISSUE);
  assign mem_rw    = mem_en & r_rw;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign busy      = (r_state != IDLE);
  assign owner     = r_owner;

  assign w_ack     = (r_state == ACK);
  assign cpu_ack   = w_ack & (r_owner == OWN_CPU);
  assign con_ack   = w_ack & (r_owner == OWN_CON);
  assign cpu_err   = cpu_ack & r_err;
  assign con_err   = con_ack & r_err;
  assign cpu_rdata = r_cpu_rdata;
  assign con_rdata = r_con_rdata;
endmodule

// File: doc/sam_mem_arbiter.md
Name: sam_mem_arbiter

Overview:
- Two-port arbiter/sequencer that shares the single SAM memory bus between the CPU core and the console/loader port.
- Grants one requester at a time (round-robin on ties), issues exactly one memory cycle per grant, captures read data and returns a one-cycle ack.
- Sits between Toplevel's CPU bus and the external memory. The top level keeps the tristate Data_Bus and splits it into mem_wdata/mem_rdata for this block.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MEM_DEPTH, 64, number of valid words; addresses >= MEM_DEPTH are rejected with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- cpu_req  in  1  CPU request; held until cpu_ack.
- cpu_rw  in  1  1=read, 0=write (same encoding as memory Rw).
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ack; address out of range.
- cpu_rdata  out  DW  last read data for the CPU; held until the next CPU read ack.
- con_req, con_rw, con_addr, con_wdata, con_ack, con_err, con_rdata: console port, identical semantics.
- hold_cpu  in  1  console pause; while 1, CPU requests are not granted.
- mem_en  out  1  memory enable (En).
- mem_rw  out  1  memory direction (Rw).
- mem_addr  out  AW  memory address (Address_Bus).
- mem_wdata  out  DW  write data driven onto Data_Bus when mem_en=1 and mem_rw=0.
- mem_rdata  in  DW  read data from Data_Bus; valid the cycle after a read is issued.
- busy  out  1  1 in any state other than IDLE.
- owner  out  1  current or last grant: 0=CPU, 1=console.

Behaviour:
- Reset (async, immediate):
  - State=IDLE; all ack/err/mem_en/mem_rw/busy = 0.
  - mem_addr, mem_wdata, cpu_rdata, con_rdata = 0.
  - last_owner=1, so the CPU wins the first tie.
  - Reset mid-transaction aborts it with no ack; mem_en drops without waiting for clk.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE:
  - Eligible requests: con_req, and cpu_req & ~hold_cpu.
  - None eligible -> stay in IDLE.
  - One eligible -> grant it.
  - Both eligible -> grant the requester not equal to last_owner.
  - On grant: latch rw, addr and wdata; set owner and last_owner.
  - If addr >= MEM_DEPTH -> go to ACK with err=1; no memory cycle is issued.
  - Otherwise -> go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_rw, mem_addr and mem_wdata come from the latched values.
  - Write -> go to ACK.
  - Read -> go to WAIT.
- WAIT (1 cycle): mem_en=0; mem_rdata is registered into the owner's rdata at the end of the cycle; then go to ACK.
- ACK (1 cycle): owner's ack=1; err=latched error flag; then go to IDLE.
- Latency, with req sampled in IDLE at cycle 0:
  - Write: ack in cycle 2.
  - Read: ack in cycle 3, with rdata valid in that same cycle.
  - Error: ack in cycle 1.
- Back-to-back requests: the mandatory IDLE cycle follows every ACK. A requester still holding req in that IDLE cycle is treated as issuing a new request.
- Requester drops req before ack: the latched transaction still completes and ack still pulses.
- Requester changes addr/wdata after grant: ignored, because the values are latched.
- hold_cpu asserted mid-CPU transaction: the transaction completes; only new grants are blocked.
- Non-owner outputs: ack and err stay 0; rdata is unchanged.
- Error transactions do not modify rdata.
- Address comparison is unsigned, full AW width.

Decomposition:
- Package sam_mem_pkg holds:
  - state enum {IDLE, ISSUE, WAIT, ACK};
  - constants RW_READ=1'b1, RW_WRITE=1'b0, OWN_CPU=1'b0, OWN_CON=1'b1;
  - default AW/DW/MEM_DEPTH values.
- One natural sub-module: sam_rr_pick2, a 2-way combinational round-robin selector taking (req[1:0], last_owner) and returning (grant_valid, grant_id).

Test Plan:
- CPU read, memory preloaded with Memory[19]=8'h63, cpu_req rw=1 addr=19 at cycle 0:
  - mem_en=1 with addr=19 in cycle 1 only;
  - cpu_ack=1 in cycle 3 with cpu_rdata=8'h63;
  - con_ack stays 0.
- Console write addr=5 wdata=8'hA5:
  - mem_en=1, mem_rw=0, mem_wdata=8'hA5 in cycle 1;
  - con_ack in cycle 2;
  - a subsequent CPU read of addr 5 returns 8'hA5.
- Both requesters held high continuously after reset:
  - grants alternate CPU, console, CPU, console;
  - owner toggles each transaction and no requester is starved.
- hold_cpu=1 with both requesters high: only console transactions are issued. Deasserting hold_cpu -> the next grant goes to the CPU.
- CPU read addr=8'd64: cpu_ack=1 and cpu_err=1 in cycle 1; mem_en never asserts; cpu_rdata is unchanged.
- rst pulsed in the ISSUE cycle of a read: mem_en=0 immediately; no ack; busy=0; a subsequent request completes normally.
